// File: rtl/jtag_debug_cmd_sysclk_queue.sv
// Sysclk-side JTAG debug command bridge: synchronises update-DR/IR, queues {ir, sr} commands, issues per-IR strobes.
// Define JTAG_CMD_FIFO_EN for a DEPTH-entry command queue; otherwise a single holding register is used.
module jtag_debug_cmd_sysclk_queue #(
  parameter int SR_WIDTH    = 38,
  parameter int IR_WIDTH    = 2,
  parameter int ACTION_BIT  = 34,
  parameter int SYNC_STAGES = 2,
  parameter int DEPTH       = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       vs_udr,
  input  logic                       vs_uir,
  input  logic [IR_WIDTH-1:0]        ir_in,
  input  logic [SR_WIDTH-1:0]        sr,
  input  logic                       cmd_ready,
  output logic                       cmd_valid,
`ifdef JTAG_CMD_FIFO_EN
  output logic [$clog2(DEPTH+1)-1:0] level,
`else
  output logic                       level,
`endif
  output logic [SR_WIDTH-1:0]        jdo,
  output logic [IR_WIDTH-1:0]        jdo_ir,
  output logic [2**IR_WIDTH-1:0]     take_action,
  output logic [2**IR_WIDTH-1:0]     take_no_action,
  output logic                       uir_pulse,
  output logic                       overflow
);

  localparam int NCH   = 2**IR_WIDTH;
  localparam int ENT_W = IR_WIDTH + SR_WIDTH;

  if (SYNC_STAGES < 2 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || ACTION_BIT >= SR_WIDTH) begin : g_param_check
    $error("jtag_debug_cmd_sysclk_queue: unsupported parameter set");
  end

  logic [SYNC_STAGES-1:0] udr_sync_q, udr_sync_d, uir_sync_q, uir_sync_d, fill_q, fill_d;
  logic                   udr_prev_q, udr_prev_d, uir_prev_q, uir_prev_d;
  logic                   udr_arm_q, udr_arm_d;
  logic                   udr_rise_q, udr_rise_d, uir_rise_q, uir_rise_d;
  logic [SR_WIDTH-1:0]    jdo_q, jdo_d;
  logic [IR_WIDTH-1:0]    jdo_ir_q, jdo_ir_d;
  logic [NCH-1:0]         take_action_q, take_action_d, take_no_action_q, take_no_action_d;
  logic                   uir_pulse_q, uir_pulse_d, overflow_q, overflow_d;

  logic [ENT_W-1:0]       head_ent;
  logic [IR_WIDTH-1:0]    head_ir;
  logic [SR_WIDTH-1:0]    head_sr;
  logic [NCH-1:0]         sel;
  logic                   push, pop, full, wr_en, drop;

  assign {head_ir, head_sr} = head_ent;
  assign push  = udr_rise_q;
  assign pop   = cmd_valid & cmd_ready;
  assign wr_en = push & (~full | pop);
  assign drop  = push & full & ~pop;

  // The arm flag blocks a udr level that was already high across reset from
  // counting as a rise: it needs a genuine low seen once the chain is refilled.
  always_comb begin
    udr_sync_d = {udr_sync_q[SYNC_STAGES-2:0], vs_udr};
    uir_sync_d = {uir_sync_q[SYNC_STAGES-2:0], vs_uir};
    fill_d     = {fill_q[SYNC_STAGES-2:0], 1'b1};
    udr_prev_d = udr_sync_q[SYNC_STAGES-1];
    uir_prev_d = uir_sync_q[SYNC_STAGES-1];
    udr_arm_d  = udr_arm_q | (fill_q[SYNC_STAGES-1] & ~udr_sync_q[SYNC_STAGES-1]);
    udr_rise_d = udr_sync_q[SYNC_STAGES-1] & ~udr_prev_q & udr_arm_q;
    uir_rise_d = uir_sync_q[SYNC_STAGES-1] & ~uir_prev_q;
  end

`ifdef JTAG_CMD_FIFO_EN
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH+1);

  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;

  assign full      = (level_q == LVL_W'(DEPTH));
  assign cmd_valid = (level_q != '0);
  assign head_ent  = mem_q[rd_ptr_q];
  assign level     = level_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)   rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (wr_en && !pop)      level_d = level_q + LVL_W'(1);
    else if (!wr_en && pop) level_d = level_q - LVL_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= {ir_in, sr};
  end
`else
  logic [ENT_W-1:0] hold_q;
  logic             full_q, full_d;

  assign full      = full_q;
  assign cmd_valid = full_q;
  assign head_ent  = hold_q;
  assign level     = full_q;

  always_comb begin
    full_d = full_q;
    if (wr_en)    full_d = 1'b1;
    else if (pop) full_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) full_q <= 1'b0;
    else          full_q <= full_d;
  end

  always_ff @(posedge clk) begin
    if (wr_en) hold_q <= {ir_in, sr};
  end
`endif

  // A drop in the same cycle as an IR update leaves overflow set.
  always_comb begin
    sel          = '0;
    sel[head_ir] = 1'b1;
    jdo_d            = jdo_q;
    jdo_ir_d         = jdo_ir_q;
    take_action_d    = '0;
    take_no_action_d = '0;
    if (pop) begin
      jdo_d    = head_sr;
      jdo_ir_d = head_ir;
      if (head_sr[ACTION_BIT]) take_action_d    = sel;
      else                     take_no_action_d = sel;
    end
    uir_pulse_d = uir_rise_q;
    overflow_d  = overflow_q;
    if (uir_rise_q) overflow_d = 1'b0;
    if (drop)       overflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      udr_sync_q       <= '0;
      uir_sync_q       <= '0;
      fill_q           <= '0;
      udr_prev_q       <= 1'b0;
      uir_prev_q       <= 1'b0;
      udr_arm_q        <= 1'b0;
      udr_rise_q       <= 1'b0;
      uir_rise_q       <= 1'b0;
      jdo_q            <= '0;
      jdo_ir_q         <= '0;
      take_action_q    <= '0;
      take_no_action_q <= '0;
      uir_pulse_q      <= 1'b0;
      overflow_q       <= 1'b0;
    end else begin
      udr_sync_q       <= udr_sync_d;
      uir_sync_q       <= uir_sync_d;
      fill_q           <= fill_d;
      udr_prev_q       <= udr_prev_d;
      uir_prev_q       <= uir_prev_d;
      udr_arm_q        <= udr_arm_d;
      udr_rise_q       <= udr_rise_d;
      uir_rise_q       <= uir_rise_d;
      jdo_q            <= jdo_d;
      jdo_ir_q         <= jdo_ir_d;
      take_action_q    <= take_action_d;
      take_no_action_q <= take_no_action_d;
      uir_pulse_q      <= uir_pulse_d;
      overflow_q       <= overflow_d;
    end
  end

  assign jdo            = jdo_q;
  assign jdo_ir         = jdo_ir_q;
  assign take_action    = take_action_q;
  assign take_no_action = take_no_action_q;
  assign uir_pulse      = uir_pulse_q;
  assign overflow       = overflow_q;

endmodule

// File: tb/tb_jtag_debug_cmd_sysclk_queue.sv
// Directed bench for jtag_debug_cmd_sysclk_queue; expectations follow JTAG_CMD_FIFO_EN (queue depth 4 or 1).
`timescale 1ns/1ps
module tb_jtag_debug_cmd_sysclk_queue;

`ifdef JTAG_CMD_FIFO_EN
  localparam int QD    = 4;
  localparam int LVL_W = 3;
`else
  localparam int QD    = 1;
  localparam int LVL_W = 1;
`endif
  localparam int NR = (QD < 3) ? QD : 3;

  localparam logic [37:0] SR_A = 38'h4_1234_5678;
  localparam logic [37:0] SR_B = 38'h0_89AB_CDEF;
  localparam logic [37:0] SR_C = 38'h3F_0000_0001;
  localparam logic [37:0] SR_D = 38'h1_DEAD_BEEF;
  localparam logic [37:0] SR_E = 38'h2_CAFE_F00D;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             vs_udr = 1'b0;
  logic             vs_uir = 1'b0;
  logic             cmd_ready = 1'b0;
  logic [1:0]       ir_in = '0;
  logic [37:0]      sr = '0;
  logic             cmd_valid;
  logic [LVL_W-1:0] level;
  logic [37:0]      jdo;
  logic [1:0]       jdo_ir;
  logic [3:0]       take_action, take_no_action;
  logic             uir_pulse, overflow;

  logic [37:0]      ev_sr [5];
  logic [1:0]       ev_ir [5];
  logic             strobe_seen;
  int               n_checks = 0;
  int               n_errors = 0;

  always #5 clk = ~clk;

  jtag_debug_cmd_sysclk_queue #(
    .SR_WIDTH(38), .IR_WIDTH(2), .ACTION_BIT(34), .SYNC_STAGES(2), .DEPTH(4)
  ) dut (
    .clk(clk), .reset_n(reset_n), .vs_udr(vs_udr), .vs_uir(vs_uir),
    .ir_in(ir_in), .sr(sr), .cmd_ready(cmd_ready), .cmd_valid(cmd_valid),
    .level(level), .jdo(jdo), .jdo_ir(jdo_ir), .take_action(take_action),
    .take_no_action(take_no_action), .uir_pulse(uir_pulse), .overflow(overflow)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic queue_event(input logic [1:0] ir, input logic [37:0] data);
    ir_in  = ir;
    sr     = data;
    vs_udr = 1'b1;
    repeat (4) tick();
    vs_udr = 1'b0;
    repeat (3) tick();
  endtask

  task automatic pop_one();
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
  endtask

  function automatic logic [3:0] onehot(input logic [1:0] i);
    return 4'b0001 << i;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 5; i++) begin
      ev_ir[i] = 2'(i + 1);
      ev_sr[i] = 38'h1000 + 38'(i);
      if (i % 2 == 1) ev_sr[i][34] = 1'b1;
    end

    // Reset state
    repeat (2) tick();
    check("rst_valid", 64'(cmd_valid), 64'd0);
    check("rst_level", 64'(level), 64'd0);
    check("rst_jdo", 64'(jdo), 64'd0);
    check("rst_jdo_ir", 64'(jdo_ir), 64'd0);
    check("rst_act", 64'(take_action), 64'd0);
    check("rst_noact", 64'(take_no_action), 64'd0);
    check("rst_uir", 64'(uir_pulse), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);
    reset_n = 1'b1;
    repeat (5) tick();

    // Latency and take_action
    cmd_ready = 1'b1;
    ir_in = 2'd2; sr = SR_A; vs_udr = 1'b1;
    repeat (3) tick();
    check("lat_early", 64'(cmd_valid), 64'd0);
    tick();
    check("lat_valid", 64'(cmd_valid), 64'd1);
    tick();
    check("a_jdo", 64'(jdo), 64'(SR_A));
    check("a_jdo_ir", 64'(jdo_ir), 64'd2);
    check("a_act", 64'(take_action), 64'b0100);
    check("a_noact", 64'(take_no_action), 64'd0);
    tick();
    check("a_act_1clk", 64'(take_action), 64'd0);
    check("a_empty", 64'(cmd_valid), 64'd0);
    vs_udr = 1'b0;
    repeat (3) tick();

    // take_no_action
    ir_in = 2'd1; sr = SR_B; vs_udr = 1'b1;
    repeat (5) tick();
    check("b_noact", 64'(take_no_action), 64'b0010);
    check("b_act", 64'(take_action), 64'd0);
    check("b_jdo", 64'(jdo), 64'(SR_B));
    tick();
    check("b_noact_1clk", 64'(take_no_action), 64'd0);
    vs_udr = 1'b0; cmd_ready = 1'b0;
    repeat (3) tick();

    // Overflow then ordered drain
    for (int i = 0; i <= QD; i++) queue_event(ev_ir[i], ev_sr[i]);
    check("ovf_level", 64'(level), 64'(QD));
    check("ovf_set", 64'(overflow), 64'd1);
    check("ovf_valid", 64'(cmd_valid), 64'd1);
    for (int i = 0; i < QD; i++) begin
      pop_one();
      check("drain_jdo", 64'(jdo), 64'(ev_sr[i]));
      check("drain_ir", 64'(jdo_ir), 64'(ev_ir[i]));
      check("drain_act", 64'(take_action), ev_sr[i][34] ? 64'(onehot(ev_ir[i])) : 64'd0);
      check("drain_noact", 64'(take_no_action), ev_sr[i][34] ? 64'd0 : 64'(onehot(ev_ir[i])));
      tick();
      check("drain_quiet", 64'(take_action | take_no_action), 64'd0);
    end
    check("drain_empty", 64'(level), 64'd0);
    check("ovf_sticky", 64'(overflow), 64'd1);

    cmd_ready = 1'b1;
    repeat (3) tick();
    check("empty_ready", 64'(take_action | take_no_action), 64'd0);
    cmd_ready = 1'b0;

    vs_uir = 1'b1;
    repeat (3) tick();
    check("uir_early", 64'(uir_pulse), 64'd0);
    check("uir_ovf_hold", 64'(overflow), 64'd1);
    tick();
    check("uir_pulse", 64'(uir_pulse), 64'd1);
    check("uir_ovf_clr", 64'(overflow), 64'd0);
    tick();
    check("uir_1clk", 64'(uir_pulse), 64'd0);
    vs_uir = 1'b0;
    repeat (3) tick();

    // Full queue: push and pop in the same cycle
    for (int i = 0; i < QD; i++) queue_event(ev_ir[i], ev_sr[i]);
    check("full_level", 64'(level), 64'(QD));
    ir_in = 2'd3; sr = SR_C; vs_udr = 1'b1;
    repeat (3) tick();
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    check("pp_level", 64'(level), 64'(QD));
    check("pp_ovf", 64'(overflow), 64'd0);
    check("pp_jdo", 64'(jdo), 64'(ev_sr[0]));
    vs_udr = 1'b0;
    repeat (3) tick();
    for (int i = 0; i < QD; i++) pop_one();
    check("pp_last_jdo", 64'(jdo), 64'(SR_C));
    check("pp_last_ir", 64'(jdo_ir), 64'd3);
    check("pp_empty", 64'(level), 64'd0);
    tick();

    // Held level and short pulse each push once
    ir_in = 2'd0; sr = SR_D; vs_udr = 1'b1;
    repeat (20) tick();
    vs_udr = 1'b0;
    repeat (3) tick();
    check("held_level", 64'(level), 64'd1);
    check("held_ovf", 64'(overflow), 64'd0);
    pop_one();
    check("held_jdo", 64'(jdo), 64'(SR_D));
    tick();
    ir_in = 2'd1; sr = SR_E; vs_udr = 1'b1;
    repeat (2) tick();
    vs_udr = 1'b0;
    repeat (4) tick();
    check("short_level", 64'(level), 64'd1);
    pop_one();
    check("short_jdo", 64'(jdo), 64'(SR_E));
    tick();

    // Asynchronous reset mid-operation with a pending udr level
    for (int i = 0; i < NR; i++) queue_event(ev_ir[i], ev_sr[i]);
    check("pre_rst_level", 64'(level), 64'(NR));
    ir_in = 2'd2; sr = SR_A; vs_udr = 1'b1;
    tick();
    #2 reset_n = 1'b0;
    #1;
    check("arst_level", 64'(level), 64'd0);
    check("arst_valid", 64'(cmd_valid), 64'd0);
    check("arst_jdo", 64'(jdo), 64'd0);
    check("arst_jdo_ir", 64'(jdo_ir), 64'd0);
    check("arst_strobes", 64'(take_action | take_no_action), 64'd0);
    check("arst_ovf", 64'(overflow), 64'd0);
    cmd_ready = 1'b1;
    #3 reset_n = 1'b1;
    strobe_seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      strobe_seen = strobe_seen | (|take_action) | (|take_no_action);
    end
    check("post_rst_strobe", 64'(strobe_seen), 64'd0);
    check("post_rst_level", 64'(level), 64'd0);
    cmd_ready = 1'b0; vs_udr = 1'b0;
    repeat (3) tick();
    vs_udr = 1'b1;
    repeat (4) tick();
    check("redetect_level", 64'(level), 64'd1);
    vs_udr = 1'b0;
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
